// File: rtl/adv_cfg_sequencer.sv
// Power-up and register-init sequencer for the ADV7393 video encoder.
// Pulses the encoder reset, lets it settle, then streams init-ROM entries to the config bus master.
module adv_cfg_sequencer #(
    parameter int RST_TICKS  = 16,
    parameter int WAIT_TICKS = 1000,
    parameter int NUM_REGS   = 32,
    parameter int DELAY_UNIT = 256,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          adv_rst_n,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [7:0]    wr_reg,
    output logic [7:0]    wr_data,
    input  logic          wr_err,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_index
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_ASSERT, S_RST_WAIT, S_FETCH, S_LOAD,
        S_WRITE, S_DELAY, S_DONE, S_ERR
    } state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
    localparam logic [31:0]   RST_LOAD  = 32'(RST_TICKS - 1);
    localparam logic [31:0]   WAIT_LOAD = 32'(WAIT_TICKS - 1);

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic [31:0]   cnt_r;

    logic [31:0]   delay_cnt_s;
    logic [AW-1:0] idx_next_s;
    logic          last_s;
    logic          is_delay_s;

    // Decode of the current ROM word and the next index
    always_comb begin
        delay_cnt_s = 32'(rom_data[7:0]) * 32'(DELAY_UNIT);
        idx_next_s  = idx_r + AW'(1);
        last_s      = (idx_r == LAST_IDX);
        is_delay_s  = (rom_data[15:8] == 8'hFF);
    end

    // Sequencer state machine; every output is a register updated on entry to its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            idx_r     <= '0;
            cnt_r     <= 32'd0;
            adv_rst_n <= 1'b0;
            rom_addr  <= '0;
            wr_valid  <= 1'b0;
            wr_reg    <= 8'h00;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        busy      <= 1'b1;
                        idx_r     <= '0;
                        adv_rst_n <= 1'b0;
                        cnt_r     <= RST_LOAD;
                        state_r   <= S_RST_ASSERT;
                    end
                end
                S_RST_ASSERT: begin
                    if (cnt_r == 32'd0) begin
                        adv_rst_n <= 1'b1;
                        cnt_r     <= WAIT_LOAD;
                        state_r   <= S_RST_WAIT;
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (cnt_r == 32'd0) begin
                        rom_addr <= idx_r;
                        state_r  <= S_FETCH;
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                S_FETCH: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    if (is_delay_s) begin
                        cnt_r   <= delay_cnt_s;
                        state_r <= S_DELAY;
                    end else begin
                        wr_reg   <= rom_data[15:8];
                        wr_data  <= rom_data[7:0];
                        wr_valid <= 1'b1;
                        state_r  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (wr_err) begin
                            err_index <= idx_r;
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= S_ERR;
                        end else if (last_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r    <= idx_next_s;
                            rom_addr <= idx_next_s;
                            state_r  <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    // A zero-length delay still spends one cycle here
                    if (cnt_r <= 32'd1) begin
                        if (last_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r    <= idx_next_s;
                            rom_addr <= idx_next_s;
                            state_r  <= S_FETCH;
                        end
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                default: begin
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
